// File: rtl/serial_byte_bridge.sv
// Client-side UART bridge: TX and RX byte FIFOs joined to the serial link by
// two small strobe FSMs. txready/rxready are double-flopped into this clock.
module serial_byte_bridge #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] tx_byte,
    input  logic       tx_push,
    output logic       tx_full,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_pop,
    output logic [7:0] txdata,
    output logic       txclk,
    input  logic       txready,
    input  logic [7:0] rxdata,
    input  logic       rxready,
    output logic       rxclk
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SETUP = 2'd1;
    localparam logic [1:0] TX_HOLD  = 2'd2;

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_ACK  = 1'b1;

    logic         r_txr_meta, r_txr_s;
    logic         r_rxr_meta, r_rxr_s;

    logic [7:0]   r_tx_mem [DEPTH];
    logic [AW:0]  r_tx_wptr, r_tx_rptr;
    logic [7:0]   r_rx_mem [DEPTH];
    logic [AW:0]  r_rx_wptr, r_rx_rptr;

    logic [1:0]   r_tx_state;
    logic [0:0]   r_rx_state;
    logic [7:0]   r_txdata;
    logic         r_txclk;
    logic         r_rxclk;

    logic         w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic         w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

    // Two-flop synchronizers; the FSMs never look at the raw inputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_txr_meta <= 1'b0;
            r_txr_s    <= 1'b0;
            r_rxr_meta <= 1'b0;
            r_rxr_s    <= 1'b0;
        end else begin
            r_txr_meta <= txready;
            r_txr_s    <= r_txr_meta;
            r_rxr_meta <= rxready;
            r_rxr_s    <= r_rxr_meta;
        end
    end

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                        (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_tx_push  = tx_push && !w_tx_full;
    // The FIFO cannot be empty in TX_HOLD: the head is only released here.
    assign w_tx_pop   = (r_tx_state == TX_HOLD) && !r_txr_s;

    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
    assign w_rx_push  = (r_rx_state == RX_IDLE) && r_rxr_s && !w_rx_full;
    assign w_rx_pop   = rx_pop && !w_rx_empty;

    // NOTE: FIFO storage is deliberately not reset; the pointers alone say which entries are live.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= tx_byte;
        if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= rxdata;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
        end
    end

    // txdata is loaded one cycle before txclk rises so the UART sees setup time.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tx_state <= TX_IDLE;
            r_txdata   <= 8'h00;
            r_txclk    <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_txr_s && !w_tx_empty) begin
                        r_txdata   <= r_tx_mem[r_tx_rptr[AW-1:0]];
                        r_tx_state <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    r_txclk    <= 1'b1;
                    r_tx_state <= TX_HOLD;
                end
                TX_HOLD: begin
                    if (!r_txr_s) begin
                        r_txclk    <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_txclk    <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // A full RX FIFO simply withholds the ack, stalling the UART rather than dropping.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rx_state <= RX_IDLE;
            r_rxclk    <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_push) begin
                        r_rxclk    <= 1'b1;
                        r_rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!r_rxr_s) begin
                        r_rxclk    <= 1'b0;
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_rxclk    <= 1'b0;
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign tx_full  = w_tx_full;
    assign rx_valid = !w_rx_empty;
    assign rx_byte  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[AW-1:0]];
    assign txdata   = r_txdata;
    assign txclk    = r_txclk;
    assign rxclk    = r_rxclk;

endmodule

// File: tb/tb_serial_byte_bridge.sv
// Bench for serial_byte_bridge: directed protocol scenarios, then a randomized
// run against queue-based models of both FIFOs and a model UART on each side.
module tb_serial_byte_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] tx_byte;
    logic       tx_push;
    logic       tx_full;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_pop;
    logic [7:0] txdata;
    logic       txclk;
    logic       txready;
    logic [7:0] rxdata;
    logic       rxready;
    logic       rxclk;

    always #5 clk = ~clk;

    serial_byte_bridge #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .tx_byte  (tx_byte),
        .tx_push  (tx_push),
        .tx_full  (tx_full),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_pop   (rx_pop),
        .txdata   (txdata),
        .txclk    (txclk),
        .txready  (txready),
        .rxdata   (rxdata),
        .rxready  (rxready),
        .rxclk    (rxclk)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string t);
        check({t, "_txclk"},    32'(txclk),    0);
        check({t, "_rxclk"},    32'(rxclk),    0);
        check({t, "_txdata"},   32'(txdata),   0);
        check({t, "_rx_byte"},  32'(rx_byte),  0);
        check({t, "_rx_valid"}, 32'(rx_valid), 0);
        check({t, "_tx_full"},  32'(tx_full),  0);
    endtask

    // Model UART receive side of the TX link: one byte per txclk rising edge.
    logic [7:0] got_tx[$];

    task automatic uart_tx_run(input int cycles);
        logic prev;
        prev = txclk;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (txclk && !prev) got_tx.push_back(txdata);
            prev    = txclk;
            txready = !txclk;
        end
    endtask

    // Model UART transmit side of the RX link, bounded wait on each handshake phase.
    task automatic rx_send(input logic [7:0] b);
        int k;
        rxdata  = b;
        rxready = 1'b1;
        k = 0;
        while (!rxclk && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rx_send_ack", 32'(rxclk), 1);
        rxready = 1'b0;
        k = 0;
        while (rxclk && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rx_send_release", 32'(rxclk), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Randomized-phase state
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_occ;
    int         pre_rx;
    logic       drv_push_ok, drv_pop_ok;
    logic [7:0] drv_byte;
    logic       p_txclk, p_rxclk;
    logic [7:0] p_txdata;
    int         tu_state, tu_cnt;
    int         ru_state, ru_cnt, ru_wait, ru_max_wait;

    initial begin
        int hi;
        int k;
        logic [7:0] bp[4];

        nrst = 1'b0; tx_push = 1'b0; tx_byte = 8'h00; rx_pop = 1'b0;
        txready = 1'b0; rxready = 1'b0; rxdata = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        nrst = 1'b1;

        // ---- single TX byte ----
        txready = 1'b1;
        repeat (3) @(negedge clk);
        tx_byte = 8'hA5; tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
        check("tx1_data_after_p", 32'(txdata), 0);
        @(negedge clk);
        check("tx1_data_after_p1", 32'(txdata), 32'hA5);
        check("tx1_clk_after_p1",  32'(txclk), 0);
        @(negedge clk);
        check("tx1_clk_after_p2",  32'(txclk), 1);
        check("tx1_data_after_p2", 32'(txdata), 32'hA5);
        txready = 1'b0;
        repeat (2) @(negedge clk);
        check("tx1_clk_held", 32'(txclk), 1);
        @(negedge clk);
        check("tx1_clk_released", 32'(txclk), 0);
        check("tx1_full", 32'(tx_full), 0);
        txready = 1'b1;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (txclk) hi++;
        end
        check("tx1_no_second_strobe", 32'(hi), 0);

        // ---- TX burst into a full FIFO ----
        txready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            tx_byte = 8'(i);
            tx_push = 1'b1;
            @(negedge clk);
            check($sformatf("burst_full_after_push%0d", i), 32'(tx_full), (i >= 4) ? 1 : 0);
        end
        tx_push = 1'b0;
        got_tx.delete();
        uart_tx_run(100);
        check("burst_strobe_count", 32'(got_tx.size()), 4);
        for (int i = 0; i < got_tx.size(); i++)
            check($sformatf("burst_byte%0d", i), 32'(got_tx[i]), i + 1);
        check("burst_full_drained", 32'(tx_full), 0);

        // ---- single RX byte ----
        rxdata = 8'h3C; rxready = 1'b1;
        @(negedge clk);
        check("rx1_clk_e1", 32'(rxclk), 0);
        @(negedge clk);
        check("rx1_clk_e2",   32'(rxclk), 0);
        check("rx1_valid_e2", 32'(rx_valid), 0);
        @(negedge clk);
        check("rx1_clk_e3",   32'(rxclk), 1);
        check("rx1_valid_e3", 32'(rx_valid), 1);
        check("rx1_byte_e3",  32'(rx_byte), 32'h3C);
        rxready = 1'b0;
        repeat (2) @(negedge clk);
        check("rx1_clk_held", 32'(rxclk), 1);
        @(negedge clk);
        check("rx1_clk_released", 32'(rxclk), 0);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        check("rx1_valid_after_pop", 32'(rx_valid), 0);

        // ---- RX backpressure ----
        for (int i = 0; i < 4; i++) begin
            bp[i] = 8'($urandom);
            rx_send(bp[i]);
        end
        check("bp_valid", 32'(rx_valid), 1);
        rxdata = 8'hEE; rxready = 1'b1;
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (rxclk) hi++;
        end
        check("bp_no_ack_while_full", 32'(hi), 0);
        check("bp_head", 32'(rx_byte), 32'(bp[0]));
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        check("bp_clk_pop_edge", 32'(rxclk), 0);
        @(negedge clk);
        check("bp_ack_after_pop", 32'(rxclk), 1);
        rxready = 1'b0;
        k = 0;
        while (rxclk && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("bp_release", 32'(rxclk), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_drain%0d", i), 32'(rx_byte), (i < 3) ? 32'(bp[i + 1]) : 32'hEE);
            rx_pop = 1'b1;
            @(negedge clk);
            rx_pop = 1'b0;
        end
        check("bp_empty", 32'(rx_valid), 0);

        // ---- concurrent TX and RX with same-cycle RX push/pop ----
        txready = 1'b1;
        repeat (3) @(negedge clk);
        rx_send(8'h10);
        tx_byte = 8'h55; tx_push = 1'b1;
        rxdata  = 8'hAA; rxready = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
        @(negedge clk);
        check("cc_txdata",   32'(txdata), 32'h55);
        check("cc_rxclk_e2", 32'(rxclk), 0);
        check("cc_head_e2",  32'(rx_byte), 32'h10);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        check("cc_txclk",    32'(txclk), 1);
        check("cc_rxclk",    32'(rxclk), 1);
        check("cc_rx_valid", 32'(rx_valid), 1);
        check("cc_rx_byte",  32'(rx_byte), 32'hAA);
        txready = 1'b0; rxready = 1'b0;
        repeat (3) @(negedge clk);
        check("cc_txclk_released", 32'(txclk), 0);
        check("cc_rxclk_released", 32'(rxclk), 0);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        check("cc_occupancy_one", 32'(rx_valid), 0);

        // ---- asynchronous reset mid-transfer ----
        txready = 1'b1;
        repeat (3) @(negedge clk);
        rx_send(8'h11);
        tx_byte = 8'h77; tx_push = 1'b1;
        rxdata  = 8'h22; rxready = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_txclk", 32'(txclk), 1);
        check("rst_pre_rxclk", 32'(rxclk), 1);
        #2 nrst = 1'b0;
        #1 check_idle("rst_async");
        txready = 1'b0; rxready = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("rst_after_release");

        // ---- randomized traffic against queue models ----
        tx_occ = 0; drv_push_ok = 1'b0; drv_pop_ok = 1'b0; drv_byte = 8'h00;
        p_txclk = 1'b0; p_rxclk = 1'b0; p_txdata = txdata;
        tu_state = 0; tu_cnt = 0; txready = 1'b1;
        ru_state = 0; ru_cnt = 0; ru_wait = 0; ru_max_wait = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            pre_rx = rx_exp.size();
            if (drv_push_ok) begin
                tx_exp.push_back(drv_byte);
                tx_occ++;
            end
            if (drv_pop_ok) void'(rx_exp.pop_front());

            if (txclk && !p_txclk) begin
                check("rnd_tx_strobe_has_byte", 32'(tx_exp.size() != 0), 1);
                if (tx_exp.size() != 0) check("rnd_tx_byte", 32'(txdata), 32'(tx_exp.pop_front()));
                check("rnd_tx_setup", 32'(txdata), 32'(p_txdata));
            end
            if (txclk && p_txclk) check("rnd_tx_hold", 32'(txdata), 32'(p_txdata));
            if (!txclk && p_txclk) tx_occ--;
            check("rnd_tx_full", 32'(tx_full), 32'(tx_occ == DEPTH));

            if (rxclk && !p_rxclk) begin
                check("rnd_rx_ack_when_offered", 32'(ru_state == 1), 1);
                check("rnd_rx_no_overflow", 32'(pre_rx < DEPTH), 1);
                rx_exp.push_back(rxdata);
            end
            check("rnd_rx_valid", 32'(rx_valid), 32'(rx_exp.size() != 0));
            check("rnd_rx_byte", 32'(rx_byte), (rx_exp.size() != 0) ? 32'(rx_exp[0]) : 0);

            case (tu_state)
                0: if (txclk) begin tu_cnt = $urandom_range(0, 2); tu_state = 1; end
                1: if (tu_cnt > 0) tu_cnt--; else begin txready = 1'b0; tu_state = 2; end
                2: if (!txclk) begin tu_cnt = $urandom_range(0, 4); tu_state = 3; end
                default: if (tu_cnt > 0) tu_cnt--; else begin txready = 1'b1; tu_state = 0; end
            endcase

            case (ru_state)
                0: begin
                    if (ru_cnt > 0) ru_cnt--;
                    else if (cyc < 3000 && $urandom_range(0, 3) == 0) begin
                        rxdata = 8'($urandom); rxready = 1'b1; ru_state = 1; ru_wait = 0;
                    end
                end
                1: begin
                    if (rxclk) begin ru_cnt = $urandom_range(0, 2); ru_state = 2; end
                    else begin
                        ru_wait++;
                        if (ru_wait > ru_max_wait) ru_max_wait = ru_wait;
                    end
                end
                2: if (ru_cnt > 0) ru_cnt--; else begin rxready = 1'b0; ru_state = 3; end
                default: if (!rxclk) begin ru_cnt = $urandom_range(0, 3); ru_state = 0; end
            endcase

            if (cyc < 3000) begin
                tx_push = ($urandom_range(0, 2) == 0);
                tx_byte = 8'($urandom);
            end else begin
                tx_push = 1'b0;
            end
            drv_push_ok = tx_push && (tx_occ != DEPTH);
            drv_byte    = tx_byte;
            rx_pop      = ($urandom_range(0, 1) == 0);
            drv_pop_ok  = rx_pop && (rx_exp.size() != 0);
            p_txclk  = txclk;
            p_rxclk  = rxclk;
            p_txdata = txdata;
        end
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        check("rnd_tx_all_sent", 32'(tx_exp.size()), 0);
        check("rnd_tx_fifo_empty", 32'(tx_occ), 0);
        check("rnd_rx_ack_bounded", 32'(ru_max_wait < 300), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_byte_bridge.md
# serial_byte_bridge

Client-side endpoint of the board UART link, sitting inside `top` on the system clock. Transmit direction: queues bytes from design logic and presents them one at a time on `txdata`/`txclk`, paced by `txready`. Receive direction: accepts bytes from `rxdata`/`rxready`, acknowledges each with `rxclk`, and queues them for design logic. `txready` and `rxready` arrive from the serial-clock domain and are synchronized here.

## Interface
- `DEPTH`, 4: entries in each FIFO (TX and RX); power of two, 2..16.
- `clk`  in  1  system clock (hwclk domain); one clock; all state on rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `tx_byte`  in  8  byte to enqueue for transmission.
- `tx_push`  in  1  enqueue `tx_byte` this cycle; ignored while `tx_full`=1.
- `tx_full`  out  1  TX FIFO holds DEPTH entries.
- `rx_byte`  out  8  head of RX FIFO (show-ahead); valid when `rx_valid`=1.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_pop`  in  1  dequeue head; ignored while `rx_valid`=0.
- `txdata`  out  8  byte offered to UART.
- `txclk`  out  1  rising edge requests UART to take `txdata`.
- `txready`  in  1  UART can accept a byte (async, serial domain).
- `rxdata`  in  8  byte from UART; stable while `rxready`=1.
- `rxready`  in  1  UART holds a received byte (async).
- `rxclk`  out  1  rising edge acknowledges `rxdata`.

## Operation
- Synchronizers: `txready` and `rxready` each pass through two flops (reset 0); FSMs use only the synchronized signals `txr_s`, `rxr_s`.
- FIFOs: circular, pointers log2(DEPTH)+1 bits, full = pointers equal except MSB, empty = equal. Push and pop in the same cycle both take effect when legal (push needs not full, pop needs not empty, judged on pre-edge state).
- TX FSM states TX_IDLE, TX_SETUP, TX_HOLD:
  - TX_IDLE: if `txr_s`=1 and TX FIFO non-empty, load `txdata` from head, go TX_SETUP.
  - TX_SETUP: `txclk`←1, go TX_HOLD (gives `txdata` one cycle setup before `txclk` rises).
  - TX_HOLD: hold `txclk`=1 and `txdata`. When `txr_s`=0: `txclk`←0, pop TX FIFO, go TX_IDLE.
  - `txdata` changes only on TX_IDLE→TX_SETUP; retains last byte otherwise.
- RX FSM states RX_IDLE, RX_ACK:
  - RX_IDLE: if `rxr_s`=1 and RX FIFO not full, push `rxdata`, `rxclk`←1, go RX_ACK. If full, wait (no ack = backpressure; no byte dropped here).
  - RX_ACK: hold `rxclk`=1 until `rxr_s`=0, then `rxclk`←0, go RX_IDLE.
  - Exactly one push per `rxready` high period.
- TX and RX FSMs are independent and may be active simultaneously.

## Timing
- Reset (nrst low, async): `txclk`=0, `rxclk`=0, `txdata`=8'h00, `rx_byte`=8'h00 (reads empty head), `rx_valid`=0, `tx_full`=0, FSMs idle, FIFOs empty, synchronizers 0. Mid-operation reset drops `txclk`/`rxclk` immediately; in-flight and queued bytes are discarded.
- RX latency: `rxready` rising before edge E1 → `rxr_s` high after E2 → `rx_valid`=1 and `rxclk`=1 after E3 (if FIFO was empty and not full).
- RX release: `rxready` falls before edge F1 → `rxclk`=0 after F3.
- TX latency, `txready` already synchronized high, FIFO empty: `tx_push` at edge P → `txdata` valid after P+1, `txclk`=1 after P+2.
- TX release: `txready` falls before G1 → `txclk`=0 and FIFO pop after G3; next byte needs `txr_s`=1 again (min 1 cycle in TX_IDLE).
- `tx_full` and `rx_valid` update the edge after the causing push/pop.

## Test plan
- Reset: drive `nrst`=0 mid-TX_HOLD with `txclk`=1 → `txclk`=0 immediately, all outputs at reset values, `rx_valid`=0 after release.
- Single TX: `txready`=1, push 8'hA5 → `txdata`=8'hA5 one cycle before `txclk` rises; drop `txready` → `txclk`=0 three edges later, `tx_full`=0, no second strobe.
- TX burst/full (DEPTH=4): push 8'h01..8'h05 back-to-back with `txready`=0 → `tx_full`=1 after fourth push, 8'h05 ignored; model UART → bytes 01,02,03,04 emitted in order, one `txclk` pulse each.
- Single RX: `rxdata`=8'h3C, raise `rxready` → `rxclk`=1 and `rx_valid`=1, `rx_byte`=8'h3C after third edge; lower `rxready` → `rxclk`=0 three edges later; `rx_pop` → `rx_valid`=0.
- RX backpressure: fill RX FIFO with 4 bytes, present fifth (8'hEE) → `rxclk` stays 0; one `rx_pop` → `rxclk` rises within 1 edge, 8'hEE queued last.
- Concurrent: simultaneous TX of 8'h55 and RX of 8'hAA plus same-cycle `rx_pop`/push at RX FIFO occupancy 1 → both transfers complete, occupancy unchanged, data order preserved.
